// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet accelerator and its image front end.
// Frame geometry, pixel type and loader FSM states live here so every block agrees.
package lenet_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned IMG_DIM    = 28;
    localparam int unsigned IMG_PIXELS = IMG_DIM * IMG_DIM;

    typedef logic signed [DATA_W-1:0] pixel_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } loader_state_t;

endpackage

// File: rtl/lenet_rowcol_counter.sv
// Row-major frame position counter: col wraps at IMG_DIM-1 and carries into row.
// last_o flags the final pixel position of the frame.
module lenet_rowcol_counter #(
    parameter int unsigned IMG_DIM = 28,
    parameter int unsigned CW      = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic          last_o
);

    localparam logic [CW-1:0] POS_MAX = CW'(IMG_DIM - 1);

    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (inc_i) begin
            if (col_q == POS_MAX) begin
                col_d = '0;
                row_d = (row_q == POS_MAX) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == POS_MAX) && (col_q == POS_MAX);

endmodule

// File: rtl/lenet_image_loader.sv
// Pixel-stream writer for the accelerator image buffer: fills a frame row-major,
// then holds it with frame_valid until frame_ack releases it.
module lenet_image_loader #(
    parameter int unsigned bitwidth = 16,
    parameter int unsigned IMG_DIM  = 28
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic [bitwidth-1:0]                           s_data,
    input  logic                                          s_last,
    output logic [IMG_DIM-1:0][IMG_DIM-1:0][bitwidth-1:0] image,
    output logic                                          frame_valid,
    input  logic                                          frame_ack,
    output logic                                          err_last,
    input  logic                                          err_clr,
    output logic [15:0]                                   frame_count
);

    import lenet_pkg::*;

    localparam int unsigned CW = $clog2(IMG_DIM);

    loader_state_t state_q, state_d;
    logic          s_ready_q;
    logic          frame_valid_q;
    logic          err_q, err_d;
    logic [15:0]   count_q, count_d;
    logic [IMG_DIM-1:0][IMG_DIM-1:0][bitwidth-1:0] image_q;

    logic          accept;
    logic          last_pix;
    logic          frame_done;
    logic          early_last;
    logic          err_event;
    logic [CW-1:0] row;
    logic [CW-1:0] col;

    assign accept     = s_valid && s_ready_q;
    assign frame_done = accept && last_pix;
    assign early_last = accept && s_last && !last_pix;
    assign err_event  = early_last || (frame_done && !s_last);

    // Early s_last discards the partial frame; the final pixel wraps the counter itself.
    lenet_rowcol_counter #(
        .IMG_DIM (IMG_DIM),
        .CW      (CW)
    ) u_pos (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (early_last),
        .inc_i  (accept && !early_last),
        .row_o  (row),
        .col_o  (col),
        .last_o (last_pix)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            FILL: begin
                if (frame_done) begin
                    state_d = HOLD;
                    count_d = count_q + 16'd1;
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        if (err_event) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= FILL;
            s_ready_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            s_ready_q     <= (state_d == FILL);
            frame_valid_q <= (state_d == HOLD);
            err_q         <= err_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            image_q <= '0;
        end else if (accept) begin
            image_q[row][col] <= s_data;
        end
    end

    assign s_ready     = s_ready_q;
    assign frame_valid = frame_valid_q;
    assign err_last    = err_q;
    assign frame_count = count_q;
    assign image       = image_q;

endmodule

// File: tb/tb_lenet_image_loader.sv
// Directed-sequence bench for lenet_image_loader with randomized data and gaps,
// checked against a pixel-index reference model of the frame buffer.
module tb_lenet_image_loader;

    localparam int BW  = 16;
    localparam int DIM = 28;
    localparam int NPIX = DIM * DIM;

    logic                              clk = 1'b0;
    logic                              rst_n;
    logic                              s_valid;
    logic                              s_ready;
    logic [BW-1:0]                     s_data;
    logic                              s_last;
    logic [DIM-1:0][DIM-1:0][BW-1:0]   image;
    logic                              frame_valid;
    logic                              frame_ack;
    logic                              err_last;
    logic                              err_clr;
    logic [15:0]                       frame_count;

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] m_img [DIM][DIM];
    int            m_k;
    int            m_cnt;
    logic          m_err;
    logic          m_fv;

    lenet_image_loader #(
        .bitwidth (BW),
        .IMG_DIM  (DIM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .image       (image),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .err_last    (err_last),
        .err_clr     (err_clr),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                m_img[r][c] = '0;
        m_k = 0; m_cnt = 0; m_err = 1'b0; m_fv = 1'b0;
    endtask

    task automatic chk_img(input string tag);
        int bad;
        bad = 0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                if (image[r][c] !== m_img[r][c]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_fv"},  frame_valid, m_fv);
        chk({tag, "_err"}, err_last, m_err);
        chk({tag, "_cnt"}, frame_count, m_cnt[15:0]);
    endtask

    // One pixel transfer; s_valid is randomly withheld for gap percent of cycles.
    task automatic xfer(input logic [BW-1:0] d, input logic last, input int gap);
        bit done;
        bit acc;
        bit ev;
        done = 0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            s_data  = d;
            s_last  = last;
            s_valid = ($urandom_range(99) >= gap);
            acc = s_valid && s_ready;
            ev  = 0;
            if (acc) begin
                m_img[m_k / DIM][m_k % DIM] = d;
                if (m_k == NPIX - 1) begin
                    m_fv = 1'b1;
                    m_cnt = (m_cnt + 1) % 65536;
                    ev = !last;
                    m_k = 0;
                end else if (last) begin
                    ev = 1;
                    m_k = 0;
                end else begin
                    m_k++;
                end
            end
            m_err = ev ? 1'b1 : (err_clr ? 1'b0 : m_err);
            tick();
            done = acc;
        end
        s_valid = 1'b0;
        if (!done) chk("xfer_timeout", 1, 0);
    endtask

    // mode 0: ramp k, 1: -k, 2: random data
    task automatic send_frame(input int mode, input int gap, input int n, input int last_at);
        logic [BW-1:0] d;
        for (int k = 0; k < n; k++) begin
            case (mode)
                0:       d = BW'(k);
                1:       d = BW'(-k);
                default: d = BW'($urandom);
            endcase
            if (k == NPIX - 1) chk("fv_before_last", frame_valid, 0);
            xfer(d, (k == last_at), gap);
        end
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        m_fv = 1'b0;
        chk("ack_fv", frame_valid, 0);
        chk("ack_ready", s_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        frame_ack = 1'b0; err_clr = 1'b0;
        model_reset();
        tick();
        chk("rst_ready", s_ready, 0);
        chk_status("rst");
        chk_img("rst_img");
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", s_ready, 1);

        // Ramp frame, no gaps
        send_frame(0, 0, NPIX, NPIX - 1);
        chk("ramp_fv_edge", frame_valid, 1);
        chk("ramp_ready", s_ready, 0);
        chk("ramp_3_5", image[3][5], 89);
        chk("ramp_27_27", image[27][27], 783);
        chk_img("ramp_img");
        chk_status("ramp");

        // HOLD ignores incoming data
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = 16'h7FFF; s_last = 1'b0;
            tick();
        end
        s_valid = 1'b0;
        chk("hold_ready", s_ready, 0);
        chk_img("hold_img");
        ack();

        // Negative ramp with backpressure gaps
        send_frame(1, 50, NPIX, NPIX - 1);
        chk("neg_1_0", image[1][0], 16'hFFE4);
        chk_img("neg_img");
        chk_status("neg");
        ack();

        // Early s_last at k=100
        send_frame(2, 30, 101, 100);
        chk_img("early_img");
        chk_status("early");
        send_frame(0, 20, NPIX, NPIX - 1);
        chk_img("after_early_img");
        chk_status("after_early");
        err_clr = 1'b1;
        m_err = 1'b0;
        tick();
        err_clr = 1'b0;
        chk("err_clr", err_last, 0);
        ack();

        // Missing s_last, with err_clr on the same edge: error must win
        send_frame(2, 10, NPIX - 1, -1);
        err_clr = 1'b1;
        xfer(BW'($urandom), 1'b0, 0);
        err_clr = 1'b0;
        chk_img("nolast_img");
        chk_status("nolast");

        // frame_ack while in FILL is ignored
        ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("ack_in_fill_ready", s_ready, 1);

        // Reset after 400 pixels
        send_frame(2, 25, 400, -1);
        rst_n = 1'b0;
        tick();
        model_reset();
        chk("midrst_ready", s_ready, 0);
        chk_status("midrst");
        chk_img("midrst_img");
        rst_n = 1'b1;
        tick();
        chk("midrst_ready_after", s_ready, 1);
        xfer(16'h1234, 1'b0, 0);
        xfer(16'hABCD, 1'b0, 0);
        chk("restart_0_0", image[0][0], 16'h1234);
        chk("restart_0_1", image[0][1], 16'hABCD);
        chk_img("restart_img");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
